// File: rtl/sid_pkg.sv
// rtl/sid_pkg.sv - shared widths, slot state codes and helpers for the SID output mixer
package sid_pkg;

    localparam int VOICE_W = 12;
    localparam int ENV_W   = 8;
    localparam int OUT_W   = 16;
    localparam int ACC_W   = 18;
    localparam int PROD_W  = 25;

    // Product windows: voice x env keeps [20:5], sum x volume keeps [19:4]
    localparam int MIX_HI = 20;
    localparam int MIX_LO = 5;
    localparam int VSC_HI = 19;
    localparam int VSC_LO = 4;

    localparam logic [4:0] SID_VOL_ADDR = 5'h18;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_V0   = 3'd1;
    localparam logic [2:0] ST_V1   = 3'd2;
    localparam logic [2:0] ST_V2   = 3'd3;
    localparam logic [2:0] ST_VOL  = 3'd4;

    // Offset-binary waveform to two's complement, sign-extended to the multiplier width
    function automatic logic signed [OUT_W-1:0] voice_to_signed(input logic [VOICE_W-1:0] v);
        return {{(OUT_W-VOICE_W+1){~v[VOICE_W-1]}}, v[VOICE_W-2:0]};
    endfunction

endpackage

// File: rtl/sid_shared_mul.sv
// rtl/sid_shared_mul.sv - single 16x9 signed multiplier shared by all mixer slots
module sid_shared_mul
    import sid_pkg::*;
(
    input  logic signed [OUT_W-1:0]  a,
    input  logic signed [8:0]        b,
    output logic signed [PROD_W-1:0] p
);

    assign p = a * b;

endmodule

// File: rtl/sid_mix_sched.sv
// rtl/sid_mix_sched.sv - four-slot time-multiplexed voice mixer with master volume scale
module sid_mix_sched
    import sid_pkg::*;
#(
    parameter bit         SATURATE  = 1'b1,
    parameter logic [3:0] VOL_RESET = 4'hF,
    parameter logic [4:0] VOL_ADDR  = SID_VOL_ADDR
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              CLKen,
    input  logic              WR,
    input  logic [4:0]        ADDR,
    input  logic [7:0]        DATA,
    input  logic [11:0]       VOICE0,
    input  logic [11:0]       VOICE1,
    input  logic [11:0]       VOICE2,
    input  logic [7:0]        ENV0,
    input  logic [7:0]        ENV1,
    input  logic [7:0]        ENV2,
    output logic [15:0]       OUTPUT,
    output logic              VALID,
    output logic              BUSY,
    output logic              OVERRUN
);

    logic [2:0]               state;
    logic                     pending;
    logic [3:0]               vol;
    logic signed [ACC_W-1:0]  acc;
    logic signed [OUT_W-1:0]  v0, v1, v2;
    logic [ENV_W-1:0]         e0, e1, e2;

    logic signed [OUT_W-1:0]  mul_a;
    logic signed [8:0]        mul_b;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  mix_term;
    logic signed [OUT_W-1:0]  mix_val;
    logic                     start;
    logic                     unused_bits;

    assign BUSY = (state != ST_IDLE);

    // A new sample is latched from IDLE, or chained straight out of the volume slot
    assign start = ((state == ST_IDLE) && CLKen) || ((state == ST_VOL) && (pending || CLKen));

    assign mix_term = {{(ACC_W-OUT_W){prod[MIX_HI]}}, prod[MIX_HI:MIX_LO]};

    always_comb begin
        mix_val = acc[OUT_W-1:0];
        if (SATURATE) begin
            if (acc > 18'sd32767) begin
                mix_val = 16'sh7FFF;
            end else if (acc < -18'sd32768) begin
                mix_val = 16'sh8000;
            end
        end
    end

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            ST_V0:   begin mul_a = v0;      mul_b = {1'b0, e0};   end
            ST_V1:   begin mul_a = v1;      mul_b = {1'b0, e1};   end
            ST_V2:   begin mul_a = v2;      mul_b = {1'b0, e2};   end
            ST_VOL:  begin mul_a = mix_val; mul_b = {5'b0, vol};  end
            default: begin mul_a = '0;      mul_b = '0;           end
        endcase
    end

    sid_shared_mul u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (prod)
    );

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state   <= ST_IDLE;
            pending <= 1'b0;
            vol     <= VOL_RESET;
            acc     <= '0;
            v0      <= '0;
            v1      <= '0;
            v2      <= '0;
            e0      <= '0;
            e1      <= '0;
            e2      <= '0;
            OUTPUT  <= '0;
            VALID   <= 1'b0;
            OVERRUN <= 1'b0;
        end else begin
            VALID <= 1'b0;
            if (WR && (ADDR == VOL_ADDR)) begin
                vol <= DATA[3:0];
            end
            case (state)
                ST_IDLE: begin
                    if (CLKen) begin
                        state <= ST_V0;
                    end
                end
                ST_V0, ST_V1, ST_V2: begin
                    acc <= acc + mix_term;
                    if (CLKen) begin
                        if (pending) begin
                            OVERRUN <= 1'b1;
                        end else begin
                            pending <= 1'b1;
                        end
                    end
                    if (state == ST_V0) begin
                        state <= ST_V1;
                    end else if (state == ST_V1) begin
                        state <= ST_V2;
                    end else begin
                        state <= ST_VOL;
                    end
                end
                ST_VOL: begin
                    OUTPUT  <= prod[VSC_HI:VSC_LO];
                    VALID   <= 1'b1;
                    pending <= 1'b0;
                    state   <= start ? ST_V0 : ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
            if (start) begin
                acc <= '0;
                v0  <= voice_to_signed(VOICE0);
                v1  <= voice_to_signed(VOICE1);
                v2  <= voice_to_signed(VOICE2);
                e0  <= ENV0;
                e1  <= ENV1;
                e2  <= ENV2;
            end
        end
    end

    assign unused_bits = ^{prod[PROD_W-1:MIX_HI+1], prod[VSC_LO-1:0], DATA[7:4]};

endmodule

// File: tb/tb_sid_mix_sched.sv
// tb/tb_sid_mix_sched.sv - self-checking bench for sid_mix_sched with a slot-count reference model
module tb_sid_mix_sched;

    logic        CLK;
    logic        RESETn;
    logic        CLKen;
    logic        WR;
    logic [4:0]  ADDR;
    logic [7:0]  DATA;
    logic [11:0] VOICE0, VOICE1, VOICE2;
    logic [7:0]  ENV0, ENV1, ENV2;
    logic [15:0] OUTPUT, OUTPUT_w;
    logic        VALID, BUSY, OVERRUN;
    logic        VALID_w, BUSY_w, OVERRUN_w;

    int checks = 0;
    int errors = 0;

    sid_mix_sched dut (
        .CLK(CLK), .RESETn(RESETn), .CLKen(CLKen), .WR(WR), .ADDR(ADDR), .DATA(DATA),
        .VOICE0(VOICE0), .VOICE1(VOICE1), .VOICE2(VOICE2),
        .ENV0(ENV0), .ENV1(ENV1), .ENV2(ENV2),
        .OUTPUT(OUTPUT), .VALID(VALID), .BUSY(BUSY), .OVERRUN(OVERRUN)
    );

    sid_mix_sched #(.SATURATE(1'b0)) dut_w (
        .CLK(CLK), .RESETn(RESETn), .CLKen(CLKen), .WR(WR), .ADDR(ADDR), .DATA(DATA),
        .VOICE0(VOICE0), .VOICE1(VOICE1), .VOICE2(VOICE2),
        .ENV0(ENV0), .ENV1(ENV1), .ENV2(ENV2),
        .OUTPUT(OUTPUT_w), .VALID(VALID_w), .BUSY(BUSY_w), .OVERRUN(OVERRUN_w)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Reference model: a sample in flight reaches its volume slot four edges after it starts
    bit       m_inflight, m_pending, m_overrun, m_valid;
    int       m_left;
    int       m_vol;
    int       m_out, m_out_w;
    int       s_v[3], s_e[3];

    function automatic int sval(input logic [11:0] v);
        return int'(v) - 2048;
    endfunction

    function automatic void take_snap();
        s_v[0] = sval(VOICE0); s_v[1] = sval(VOICE1); s_v[2] = sval(VOICE2);
        s_e[0] = int'(ENV0);   s_e[1] = int'(ENV1);   s_e[2] = int'(ENV2);
    endfunction

    function automatic void model_reset();
        m_inflight = 0; m_pending = 0; m_overrun = 0; m_valid = 0;
        m_left = 0; m_vol = 15; m_out = 0; m_out_w = 0;
    endfunction

    function automatic void model_edge();
        int sum;
        int sat;
        logic signed [15:0] wrapped;
        m_valid = 0;
        if (m_inflight && m_left == 0) begin
            sum = 0;
            for (int i = 0; i < 3; i++) sum += (s_v[i] * s_e[i]) >>> 5;
            sat = (sum > 32767) ? 32767 : (sum < -32768) ? -32768 : sum;
            wrapped = sum[15:0];
            m_out   = (sat * m_vol) >>> 4;
            m_out_w = (int'(wrapped) * m_vol) >>> 4;
            m_valid = 1;
            if (m_pending || CLKen) begin
                take_snap();
                m_pending = 0;
                m_left = 3;
            end else begin
                m_inflight = 0;
            end
        end else if (m_inflight) begin
            if (CLKen) begin
                if (m_pending) m_overrun = 1;
                else m_pending = 1;
            end
            m_left--;
        end else if (CLKen) begin
            take_snap();
            m_inflight = 1;
            m_left = 3;
        end
        if (WR && ADDR == 5'h18) m_vol = int'(DATA[3:0]);
    endfunction

    task automatic cycle();
        model_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_inputs(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c,
                              input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] ec);
        VOICE0 = a; VOICE1 = b; VOICE2 = c;
        ENV0 = ea; ENV1 = eb; ENV2 = ec;
    endtask

    task automatic do_reset();
        RESETn = 1'b0;
        CLKen = 1'b0; WR = 1'b0; ADDR = '0; DATA = '0;
        @(posedge CLK);
        #1;
        RESETn = 1'b1;
        model_reset();
    endtask

    task automatic write_vol(input logic [7:0] d);
        WR = 1'b1; ADDR = 5'h18; DATA = d;
        cycle();
        WR = 1'b0;
    endtask

    task automatic test_reset();
        RESETn = 1'b0;
        CLKen = 1'b0; WR = 1'b0; ADDR = '0; DATA = '0;
        set_inputs(12'h800, 12'h800, 12'h800, 8'd0, 8'd0, 8'd0);
        @(posedge CLK);
        #1;
        checks++; if (OUTPUT !== 16'd0) begin errors++; $display("FAIL reset_output: got %0d expected 0", OUTPUT); end
        checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", VALID); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
        checks++; if (OVERRUN !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", OVERRUN); end
        RESETn = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        do_reset();
        set_inputs(12'hFFF, 12'h800, 12'h800, 8'd255, 8'd0, 8'd0);
        CLKen = 1'b1;
        cycle();
        CLKen = 1'b0;
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", BUSY); end
        for (int k = 1; k <= 6; k++) begin
            cycle();
            checks++;
            if (VALID !== (k == 4)) begin errors++; $display("FAIL single_valid_c%0d: got %b expected %b", k, VALID, (k == 4)); end
            if (k == 4) begin
                checks++;
                if (OUTPUT !== 16'(15292)) begin errors++; $display("FAIL single_output: got %0d expected 15292", $signed(OUTPUT)); end
            end
        end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL single_idle: got %b expected 0", BUSY); end
    endtask

    task automatic run_sample(input string name, input int exp_sat, input int exp_wrap);
        CLKen = 1'b1;
        cycle();
        CLKen = 1'b0;
        for (int k = 1; k <= 4; k++) cycle();
        checks++; if (VALID !== 1'b1) begin errors++; $display("FAIL %s_valid: got %b expected 1", name, VALID); end
        checks++; if (OUTPUT !== 16'(exp_sat)) begin errors++; $display("FAIL %s_sat: got %0d expected %0d", name, $signed(OUTPUT), exp_sat); end
        checks++; if (OUTPUT_w !== 16'(exp_wrap)) begin errors++; $display("FAIL %s_wrap: got %0d expected %0d", name, $signed(OUTPUT_w), exp_wrap); end
        cycle();
    endtask

    task automatic test_saturation();
        do_reset();
        set_inputs(12'hFFF, 12'hFFF, 12'hFFF, 8'd255, 8'd255, 8'd255);
        run_sample("pos_clip", 30719, -15563);
        set_inputs(12'h000, 12'h000, 12'h000, 8'd255, 8'd255, 8'd255);
        run_sample("neg_clip", -30720, 15540);
        write_vol(8'hF0);
        run_sample("vol_zero", 0, 0);
        write_vol(8'h07);
        run_sample("vol_seven", -14336, 7252);
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_inputs(12'hFFF, 12'h800, 12'h800, 8'd255, 8'd0, 8'd0);
        for (int k = 0; k < 20; k++) begin
            CLKen = (k < 12);
            cycle();
            checks++;
            if (VALID !== (k == 4 || k == 8 || k == 12 || k == 16)) begin
                errors++; $display("FAIL b2b_valid_c%0d: got %b", k, VALID);
            end
            checks++;
            if (BUSY !== (k < 16)) begin errors++; $display("FAIL b2b_busy_c%0d: got %b expected %b", k, BUSY, (k < 16)); end
            checks++;
            if (OVERRUN !== (k >= 2)) begin errors++; $display("FAIL b2b_overrun_c%0d: got %b expected %b", k, OVERRUN, (k >= 2)); end
            if (VALID === 1'b1) begin
                checks++;
                if (OUTPUT !== 16'(15292)) begin errors++; $display("FAIL b2b_output_c%0d: got %0d expected 15292", k, $signed(OUTPUT)); end
            end
        end
        CLKen = 1'b0;
    endtask

    task automatic test_snapshot();
        do_reset();
        set_inputs(12'hFFF, 12'h800, 12'h800, 8'd255, 8'd0, 8'd0);
        for (int k = 0; k <= 9; k++) begin
            CLKen = (k == 0 || k == 1);
            cycle();
            if (k == 0) VOICE0 = 12'h000;
            if (k == 4) begin
                checks++;
                if (VALID !== 1'b1 || OUTPUT !== 16'(15292)) begin errors++; $display("FAIL snap_first: got %0d valid %b expected 15292", $signed(OUTPUT), VALID); end
            end
            if (k == 8) begin
                checks++;
                if (VALID !== 1'b1 || OUTPUT !== 16'(-15300)) begin errors++; $display("FAIL snap_second: got %0d valid %b expected -15300", $signed(OUTPUT), VALID); end
            end
        end
        CLKen = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        set_inputs(12'hFFF, 12'h800, 12'h800, 8'd255, 8'd0, 8'd0);
        write_vol(8'h03);
        for (int k = 0; k <= 5; k++) begin
            CLKen = (k < 3);
            cycle();
        end
        checks++; if (OUTPUT !== 16'(3058)) begin errors++; $display("FAIL arst_pre_output: got %0d expected 3058", $signed(OUTPUT)); end
        checks++; if (BUSY !== 1'b1 || OVERRUN !== 1'b1) begin errors++; $display("FAIL arst_pre_flags: got busy %b overrun %b expected 1 1", BUSY, OVERRUN); end
        #2;
        RESETn = 1'b0;
        #1;
        checks++; if (OUTPUT !== 16'd0) begin errors++; $display("FAIL arst_output: got %0d expected 0", OUTPUT); end
        checks++; if (VALID !== 1'b0 || BUSY !== 1'b0 || OVERRUN !== 1'b0) begin
            errors++; $display("FAIL arst_flags: got valid %b busy %b overrun %b expected 0 0 0", VALID, BUSY, OVERRUN);
        end
        @(posedge CLK);
        #1;
        RESETn = 1'b1;
        model_reset();
        for (int k = 0; k < 8; k++) begin
            cycle();
            checks++;
            if (VALID !== 1'b0) begin errors++; $display("FAIL arst_no_valid_c%0d: got %b expected 0", k, VALID); end
        end
        CLKen = 1'b1;
        cycle();
        CLKen = 1'b0;
        for (int k = 1; k <= 4; k++) cycle();
        checks++; if (VALID !== 1'b1 || OUTPUT !== 16'(15292)) begin errors++; $display("FAIL arst_vol_restored: got %0d valid %b expected 15292", $signed(OUTPUT), VALID); end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 600; k++) begin
            CLKen = ($urandom_range(0, 2) == 0);
            VOICE0 = 12'($urandom); VOICE1 = 12'($urandom); VOICE2 = 12'($urandom);
            ENV0 = 8'($urandom); ENV1 = 8'($urandom); ENV2 = 8'($urandom);
            WR = ($urandom_range(0, 9) == 0);
            ADDR = ($urandom_range(0, 1) == 0) ? 5'h18 : 5'($urandom);
            DATA = 8'($urandom);
            if (k == 300) begin
                RESETn = 1'b0;
                #1;
                RESETn = 1'b1;
                model_reset();
            end
            cycle();
            checks++;
            if (VALID !== m_valid || BUSY !== m_inflight || OVERRUN !== m_overrun) begin
                errors++;
                $display("FAIL rand_ctrl_c%0d: got valid %b busy %b overrun %b expected %b %b %b",
                         k, VALID, BUSY, OVERRUN, m_valid, m_inflight, m_overrun);
            end
            if (m_valid) begin
                checks++;
                if (OUTPUT !== 16'(m_out) || OUTPUT_w !== 16'(m_out_w)) begin
                    errors++;
                    $display("FAIL rand_output_c%0d: got %0d/%0d expected %0d/%0d",
                             k, $signed(OUTPUT), $signed(OUTPUT_w), m_out, m_out_w);
                end
            end
        end
        WR = 1'b0;
        CLKen = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_saturation();
        test_back_to_back();
        test_snapshot();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sid_mix_sched.md
Name: sid_mix_sched

Overview:
- Time-multiplexed output mixer and scheduler for the three SID voice/envelope pairs.
- Replaces three parallel multiplying DACs with one shared signed multiplier. It is sequenced over four slots per sample: voice0, voice1 and voice2 (each wave × envelope), then the master-volume scale.
- Sits between the sid_voice/sid_env instances and the audio output.
- Each 1 MHz CLKen tick starts one sample. It emits a registered 16-bit signed sample with a one-cycle valid strobe.

Parameters:
- SATURATE, 1, when 1 the three-voice sum is clipped to 16-bit signed before volume scaling; when 0 it wraps.
- VOL_RESET, 4'hF, master volume loaded at reset.
- VOL_ADDR, 5'h18, register address of the master-volume nibble.

Ports:
- CLK  input  1  master clock
- RESETn  input  1  asynchronous active-low reset
- CLKen  input  1  1 MHz sample-start enable
- WR  input  1  register write strobe
- ADDR  input  5  register address
- DATA  input  8  register write data
- VOICE0, VOICE1, VOICE2  input  12 each  unsigned (offset-binary) waveform outputs
- ENV0, ENV1, ENV2  input  8 each  unsigned envelope outputs
- OUTPUT  output  16  signed mixed sample
- VALID  output  1  one-cycle strobe, high for exactly the one cycle in which OUTPUT has just been updated
- BUSY  output  1  high while the state machine is not in IDLE
- OVERRUN  output  1  sticky flag: a start request was dropped

Behaviour:
- One clock domain; reset is asynchronous and active-low.
- Reset values: OUTPUT=0, VALID=0, BUSY=0, OVERRUN=0, vol=VOL_RESET, acc=0, pending=0, state=IDLE.
- Volume register:
  - Any cycle with WR=1 and ADDR==VOL_ADDR loads vol<=DATA[3:0]; DATA[7:4] is ignored.
  - A write takes effect at the next VOL slot, including a VOL slot in the same sample.
- Signed conversion: voice signed value = {~VOICEn[11], VOICEn[10:0]}, sign-extended to 16 bits.
- Shared multiplier:
  - Operands are a 16-bit signed value and a 9-bit signed value, giving a 25-bit signed product.
  - Exactly one instance; exactly one product per cycle.
- FSM states: IDLE, V0, V1, V2, VOL.
  - IDLE: when CLKen=1, snapshot all six voice/env inputs into registers, clear acc, go to V0.
  - V0/V1/V2: product = voice_n × {1'b0, env_n}; acc += product[20:5], sign-extended into an 18-bit accumulator. Advance to the next state.
  - VOL:
    - s = SATURATE ? clip(acc, -32768, 32767) : acc[15:0].
    - OUTPUT <= (s × {5'b0, vol})[19:4], arithmetic and floor.
    - VALID <= 1.
    - Next state: if pending or CLKen, take a new snapshot, clear pending, go to V0; else go to IDLE.
- Latency: CLKen sampled at edge t gives OUTPUT/VALID at edge t+4. Minimum start-to-start interval is 4 cycles.
- Snapshot semantics: input changes after the snapshot do not affect the sample in flight.
- CLKen while busy (states V0–V2):
  - If pending=0: set pending.
  - If pending=1: the request is dropped and OVERRUN<=1.
- CLKen in VOL is consumed directly and does not set pending.
- OVERRUN clears only on reset.
- VALID is never high for two consecutive cycles.
- Reset mid-sequence: immediate return to the reset values. The in-flight sample is discarded and no VALID is produced.

Decomposition:
- Shared package sid_pkg:
  - FSM state enum.
  - Widths: VOICE_W=12, ENV_W=8, OUT_W=16, ACC_W=18.
  - Product slice constants [20:5] and [19:4].
  - VOL_ADDR constant.
- One natural sub-module: sid_shared_mul, a 16×9 signed multiplier with operand muxing external. This keeps a later swap to a registered DSP-block multiplier local.

Test Plan:
- Single sample, all volume/saturation defaults: VOICE0=12'hFFF, ENV0=255, VOICE1=VOICE2=12'h800, ENV1=ENV2=0; pulse CLKen -> VALID exactly 4 cycles later, OUTPUT=15292 (sum 16312).
- Positive saturation: all voices 12'hFFF with env 255 -> sum 48936 clipped to 32767, OUTPUT=30719. With SATURATE=0 -> wrap to -16600, OUTPUT=-15563.
- Negative saturation: all voices 12'h000 with env 255 -> sum -48960 clipped to -32768, OUTPUT=-30720. Then write DATA=8'hF0 to ADDR 5'h18 -> vol=0, next sample OUTPUT=0.
- Back-to-back: CLKen on every cycle for 12 cycles -> VALID every 4th cycle, pending used, OVERRUN=1 after the first dropped request, BUSY continuously high.
- Snapshot: change VOICE0 from 12'hFFF to 12'h000 one cycle after CLKen -> the first sample still yields 15292, the following sample yields -15300.
- Async reset: assert RESETn=0 in state V1 -> OUTPUT/VALID/BUSY/OVERRUN=0 immediately with no clock edge, vol=15, no VALID after release until a new CLKen.
